// File: rtl/matmul_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matmul_sequencer_if                                                        |
// | Start/done handshake plus A/B bank read ports and output-memory write port |
// | Optional macro: MATMUL_SEQ_PERF_EN adds perf_cycles / perf_writes          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface matmul_sequencer_if #(
   parameter int A_ADDR_W   = 6,
   parameter int B_ADDR_W   = 6,
   parameter int OUT_ADDR_W = 12
);
   logic                  start;
   logic [A_ADDR_W:0]     cfg_rows;
   logic [B_ADDR_W:0]     cfg_cols;
   logic                  en_a;
   logic [A_ADDR_W-1:0]   addr_a;
   logic                  en_b;
   logic [B_ADDR_W-1:0]   addr_b;
   logic                  en_out;
   logic                  we_out;
   logic [OUT_ADDR_W-1:0] addr_out;
   logic                  busy;
   logic                  done;
`ifdef MATMUL_SEQ_PERF_EN
   logic [31:0]           perf_cycles;
   logic [OUT_ADDR_W:0]   perf_writes;

   modport master (
      input  start, cfg_rows, cfg_cols,
      output en_a, addr_a, en_b, addr_b, en_out, we_out, addr_out, busy, done,
      output perf_cycles, perf_writes
   );
   modport slave (
      output start, cfg_rows, cfg_cols,
      input  en_a, addr_a, en_b, addr_b, en_out, we_out, addr_out, busy, done,
      input  perf_cycles, perf_writes
   );
`else
   modport master (
      input  start, cfg_rows, cfg_cols,
      output en_a, addr_a, en_b, addr_b, en_out, we_out, addr_out, busy, done
   );
   modport slave (
      output start, cfg_rows, cfg_cols,
      input  en_a, addr_a, en_b, addr_b, en_out, we_out, addr_out, busy, done
   );
`endif
endinterface
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matmul_sequencer                                                           |
// | Issues A-row/B-column read pairs and writes tree results to output memory  |
// | Optional macro: MATMUL_SEQ_PERF_EN adds pass cycle / write counters        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module matmul_sequencer #(
   parameter int A_ADDR_W   = 6,
   parameter int B_ADDR_W   = 6,
   parameter int OUT_ADDR_W = 12,
   parameter int RD_LAT     = 1,
   parameter int TREE_LAT   = 7
) (
   input  logic               clk,
   input  logic               rst,
   matmul_sequencer_if.master bus
);
   localparam int c_lat    = RD_LAT + TREE_LAT;
   // The output register is the final tag stage, so only LAT-1 internal stages.
   localparam int c_pdepth = c_lat - 1;
   localparam logic [A_ADDR_W:0] c_max_rows = {1'b1, {A_ADDR_W{1'b0}}};
   localparam logic [B_ADDR_W:0] c_max_cols = {1'b1, {B_ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_en_a;
   logic                  r_en_b;
   logic [A_ADDR_W-1:0]   r_addr_a;
   logic [B_ADDR_W-1:0]   r_addr_b;
   logic [A_ADDR_W-1:0]   r_last_a;
   logic [B_ADDR_W-1:0]   r_last_b;
   logic [OUT_ADDR_W-1:0] r_idx;
   logic [c_pdepth-1:0]   r_pipe_vld;
   logic [OUT_ADDR_W-1:0] r_pipe_idx [c_pdepth];
   logic                  r_en_out;
   logic                  r_we_out;
   logic [OUT_ADDR_W-1:0] r_addr_out;
   logic                  r_busy;
   logic                  r_done;

   logic [A_ADDR_W:0]     w_rows;
   logic [B_ADDR_W:0]     w_cols;
   logic                  w_zero;
   logic                  w_accept;

   assign w_rows   = (bus.cfg_rows > c_max_rows) ? c_max_rows : bus.cfg_rows;
   assign w_cols   = (bus.cfg_cols > c_max_cols) ? c_max_cols : bus.cfg_cols;
   assign w_zero   = (w_rows == '0) || (w_cols == '0);
   assign w_accept = (r_state == S_IDLE) && bus.start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_en_a     <= 1'b0;
         r_en_b     <= 1'b0;
         r_addr_a   <= '0;
         r_addr_b   <= '0;
         r_last_a   <= '0;
         r_last_b   <= '0;
         r_idx      <= '0;
         r_pipe_vld <= '0;
         for (int i = 0; i < c_pdepth; i++) begin
            r_pipe_idx[i] <= '0;
         end
         r_en_out   <= 1'b0;
         r_we_out   <= 1'b0;
         r_addr_out <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_pipe_vld[0] <= r_en_a;
         r_pipe_idx[0] <= r_idx;
         for (int i = 1; i < c_pdepth; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_idx[i] <= r_pipe_idx[i-1];
         end
         r_en_out <= r_pipe_vld[c_pdepth-1];
         r_we_out <= r_pipe_vld[c_pdepth-1];
         if (r_pipe_vld[c_pdepth-1]) begin
            r_addr_out <= r_pipe_idx[c_pdepth-1];
         end
         r_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_zero) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= S_RUN;
                     r_busy   <= 1'b1;
                     r_en_a   <= 1'b1;
                     r_en_b   <= 1'b1;
                     r_addr_a <= '0;
                     r_addr_b <= '0;
                     r_idx    <= '0;
                     // Counts are 1..2^W here, so the low bits minus one give the last index.
                     r_last_a <= w_rows[A_ADDR_W-1:0] - 1;
                     r_last_b <= w_cols[B_ADDR_W-1:0] - 1;
                  end
               end
            end
            S_RUN: begin
               r_idx <= r_idx + 1;
               if (r_addr_b == r_last_b) begin
                  if (r_addr_a == r_last_a) begin
                     r_state <= S_DRAIN;
                     r_en_a  <= 1'b0;
                     r_en_b  <= 1'b0;
                  end else begin
                     r_addr_b <= '0;
                     r_addr_a <= r_addr_a + 1;
                  end
               end else begin
                  r_addr_b <= r_addr_b + 1;
               end
            end
            S_DRAIN: begin
               // Last tag sits in the output register this cycle; done follows it.
               if (r_pipe_vld == '0) begin
                  r_state <= S_FIN;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.en_a     = r_en_a;
   assign bus.en_b     = r_en_b;
   assign bus.addr_a   = r_addr_a;
   assign bus.addr_b   = r_addr_b;
   assign bus.en_out   = r_en_out;
   assign bus.we_out   = r_we_out;
   assign bus.addr_out = r_addr_out;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

`ifdef MATMUL_SEQ_PERF_EN
   logic [31:0]         r_perf_cycles;
   logic [OUT_ADDR_W:0] r_perf_writes;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_cycles <= '0;
         r_perf_writes <= '0;
      end else if (w_accept) begin
         r_perf_cycles <= '0;
         r_perf_writes <= '0;
      end else begin
         if (r_busy) begin
            r_perf_cycles <= r_perf_cycles + 1;
         end
         if (r_en_out) begin
            r_perf_writes <= r_perf_writes + 1;
         end
      end
   end

   assign bus.perf_cycles = r_perf_cycles;
   assign bus.perf_writes = r_perf_writes;
`endif

endmodule
`default_nettype wire
